// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALUOp codes (also decoded by the ALU control block) and mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JR        = 4'd12,
        S_JAL       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;

    localparam logic [2:0] ALUOP_LUI   = 3'b000;
    localparam logic [2:0] ALUOP_BR    = 3'b001;
    localparam logic [2:0] ALUOP_LW    = 3'b010;
    localparam logic [2:0] ALUOP_SW    = 3'b011;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_ORI   = 3'b101;
    localparam logic [2:0] ALUOP_ANDI  = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    function automatic logic is_rtype_funct(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) ||
               (f == F_NOR) || (f == F_SLL) || (f == F_SRL);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction fields, status inputs and datapath control lines of the multicycle controller.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               instr_done, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               instr_done, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mem_watchdog.sv
// Counts stalled cycles in a memory-wait state; flags expiry at MEM_TIMEOUT (0 = never).
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    input  logic leave,
    output logic expired
);
    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] cnt;

    // mem_ready on the expiry cycle suppresses the timeout
    assign expired = (MEM_TIMEOUT > 0) && waiting && !mem_ready && (cnt == W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset || leave || expired)
            cnt <= '0;
        else if (waiting && !mem_ready)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM; opcode 03 (JAL) is decoded only when
// MULTICYCLE_CONTROL_JAL_EN is defined, otherwise it is reported as illegal.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t state, state_next;
    logic   waiting, leave, expired;

    assign waiting = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign leave   = (state_next != state);

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .waiting   (waiting),
        .mem_ready (bus.mem_ready),
        .leave     (leave),
        .expired   (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.i_or_d      = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_source   = PCSRC_ALU;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_B;
        bus.alu_op      = ALUOP_LUI;
        bus.reg_dst     = REGDST_RT;
        bus.mem_to_reg  = M2R_ALU;
        bus.reg_write   = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;
        bus.mem_timeout = 1'b0;

        // while reset is high every control line stays low
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_4;
                    bus.alu_op    = ALUOP_ADD;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    if (bus.mem_ready) state_next = S_DECODE;
                end
                S_DECODE: begin
                    bus.alu_src_b = SRCB_IMM_SH;
                    bus.alu_op    = ALUOP_ADD;
                    state_next    = S_FETCH;
                    case (bus.opcode)
                        OP_RTYPE: begin
                            if (bus.funct == F_JR)              state_next = S_JR;
                            else if (is_rtype_funct(bus.funct)) state_next = S_R_EXEC;
                            else                                bus.illegal_op = 1'b1;
                        end
                        OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_I_EXEC;
                        OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
                        OP_J:                             state_next = S_JUMP;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                        OP_JAL:                           state_next = S_JAL;
`endif
                        default:                          bus.illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = (bus.opcode == OP_LW) ? ALUOP_LW : ALUOP_SW;
                    state_next    = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                    if (bus.mem_ready) state_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = REGDST_RT;
                    bus.mem_to_reg = M2R_MDR;
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
                S_MEM_WRITE: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                    if (bus.mem_ready) begin
                        bus.instr_done = 1'b1;
                        state_next     = S_FETCH;
                    end
                end
                S_R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_B;
                    bus.alu_op    = ALUOP_RTYPE;
                    state_next    = S_R_WB;
                end
                S_R_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = REGDST_RD;
                    bus.mem_to_reg = M2R_ALU;
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
                S_I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    case (bus.opcode)
                        OP_ORI:  bus.alu_op = ALUOP_ORI;
                        OP_ANDI: bus.alu_op = ALUOP_ANDI;
                        OP_LUI:  bus.alu_op = ALUOP_LUI;
                        default: bus.alu_op = ALUOP_ADD;
                    endcase
                    state_next = S_I_WB;
                end
                S_I_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = REGDST_RT;
                    bus.mem_to_reg = M2R_ALU;
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
                S_BRANCH: begin
                    bus.alu_src_a  = 1'b1;
                    bus.alu_src_b  = SRCB_B;
                    bus.alu_op     = ALUOP_BR;
                    bus.pc_source  = PCSRC_ALUOUT;
                    bus.pc_write   = bus.zero ^ (bus.opcode == OP_BNE);
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_source  = PCSRC_JUMP;
                    bus.pc_write   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
                S_JR: begin
                    bus.pc_source  = PCSRC_REGA;
                    bus.pc_write   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
`ifdef MULTICYCLE_CONTROL_JAL_EN
                S_JAL: begin
                    bus.pc_source  = PCSRC_JUMP;
                    bus.pc_write   = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = REGDST_RA;
                    bus.mem_to_reg = M2R_PC;
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
`endif
                default: state_next = S_FETCH;
            endcase

            // watchdog expiry abandons the access without retiring
            if (expired) begin
                bus.mem_read    = 1'b0;
                bus.mem_write   = 1'b0;
                bus.ir_write    = 1'b0;
                bus.pc_write    = 1'b0;
                bus.instr_done  = 1'b0;
                bus.mem_timeout = 1'b1;
                state_next      = S_FETCH;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, built with MEM_TIMEOUT=4.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if bus();

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit got running exp finished");
        $fatal(1, "time limit");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 6'h08; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write,
             bus.instr_done, bus.illegal_op, bus.mem_timeout, bus.alu_op, bus.alu_src_b} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs_zero got rd=%b wr=%b ir=%b pc=%b rw=%b aluop=%b srcb=%b exp all 0",
                     bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write, bus.alu_op, bus.alu_src_b);
        end
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if ({bus.mem_read, bus.i_or_d, bus.ir_write, bus.pc_write, bus.alu_op, bus.alu_src_b} !== 9'b1000_100_01) begin
            errors++;
            $display("FAIL fetch_stall got rd=%b iord=%b ir=%b pc=%b aluop=%b srcb=%b exp 1 0 0 0 100 01",
                     bus.mem_read, bus.i_or_d, bus.ir_write, bus.pc_write, bus.alu_op, bus.alu_src_b);
        end
        cyc();
        checks++;
        if ({bus.mem_read, bus.ir_write} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_still_waiting got rd=%b ir=%b exp 1 0", bus.mem_read, bus.ir_write);
        end
    endtask

    task automatic test_addi();
        bus.opcode = 6'h08; bus.mem_ready = 1'b1;
        #1;
        checks++;
        if ({bus.mem_read, bus.ir_write, bus.pc_write, bus.pc_source} !== 5'b11100) begin
            errors++;
            $display("FAIL addi_fetch got rd=%b ir=%b pc=%b pcsrc=%b exp 1 1 1 00",
                     bus.mem_read, bus.ir_write, bus.pc_write, bus.pc_source);
        end
        cyc();
        checks++;
        if ({bus.mem_read, bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== 7'b0011100) begin
            errors++;
            $display("FAIL addi_decode got rd=%b srca=%b srcb=%b aluop=%b exp 0 0 11 100",
                     bus.mem_read, bus.alu_src_a, bus.alu_src_b, bus.alu_op);
        end
        cyc();
        checks++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write} !== 7'b1101000) begin
            errors++;
            $display("FAIL addi_iexec got srca=%b srcb=%b aluop=%b rw=%b exp 1 10 100 0",
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write);
        end
        cyc();
        checks++;
        if ({bus.reg_write, bus.instr_done, bus.reg_dst, bus.mem_to_reg} !== 6'b110000) begin
            errors++;
            $display("FAIL addi_iwb got rw=%b done=%b dst=%b m2r=%b exp 1 1 00 00",
                     bus.reg_write, bus.instr_done, bus.reg_dst, bus.mem_to_reg);
        end
        cyc();
        checks++;
        if ({bus.mem_read, bus.instr_done} !== 2'b10) begin
            errors++;
            $display("FAIL addi_back_to_fetch got rd=%b done=%b exp 1 0", bus.mem_read, bus.instr_done);
        end
    endtask

    task automatic test_ori();
        bus.opcode = 6'h0D; bus.mem_ready = 1'b1;
        #1;
        repeat (2) cyc();
        checks++;
        if (bus.alu_op !== 3'b101) begin
            errors++;
            $display("FAIL ori_aluop got %b exp 101", bus.alu_op);
        end
        repeat (2) cyc();
    endtask

    task automatic test_lw();
        int rd_cycles;
        bus.opcode = 6'h23; bus.mem_ready = 1'b1;
        #1;
        cyc();
        cyc();
        checks++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== 6'b110010) begin
            errors++;
            $display("FAIL lw_memaddr got srca=%b srcb=%b aluop=%b exp 1 10 010",
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op);
        end
        bus.mem_ready = 1'b0;
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus.mem_read && bus.i_or_d) rd_cycles++;
        end
        bus.mem_ready = 1'b1;
        #1;
        if (bus.mem_read && bus.i_or_d) rd_cycles++;
        checks++;
        if (rd_cycles !== 4) begin
            errors++;
            $display("FAIL lw_mem_read_cycles got %0d exp 4", rd_cycles);
        end
        cyc();
        checks++;
        if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done, bus.mem_read} !== 7'b1000110) begin
            errors++;
            $display("FAIL lw_memwb got rw=%b dst=%b m2r=%b done=%b rd=%b exp 1 00 01 1 0",
                     bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done, bus.mem_read);
        end
        cyc();
    endtask

    task automatic test_branch();
        logic [5:0] ops [3];
        logic       zs  [3];
        logic       exp_pc [3];
        ops[0] = 6'h04; zs[0] = 1'b1; exp_pc[0] = 1'b1;
        ops[1] = 6'h05; zs[1] = 1'b1; exp_pc[1] = 1'b0;
        ops[2] = 6'h05; zs[2] = 1'b0; exp_pc[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.opcode = ops[i]; bus.zero = zs[i]; bus.mem_ready = 1'b1;
            #1;
            repeat (2) cyc();
            checks++;
            if ({bus.pc_write, bus.pc_source, bus.alu_op, bus.instr_done} !== {exp_pc[i], 2'b01, 3'b001, 1'b1}) begin
                errors++;
                $display("FAIL branch_%0d got pc=%b pcsrc=%b aluop=%b done=%b exp %b 01 001 1",
                         i, bus.pc_write, bus.pc_source, bus.alu_op, bus.instr_done, exp_pc[i]);
            end
            cyc();
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_rtype();
        bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1;
        #1;
        repeat (2) cyc();
        checks++;
        if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== 6'b100111) begin
            errors++;
            $display("FAIL rtype_exec got srca=%b srcb=%b aluop=%b exp 1 00 111",
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op);
        end
        cyc();
        checks++;
        if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done} !== 6'b101001) begin
            errors++;
            $display("FAIL rtype_wb got rw=%b dst=%b m2r=%b done=%b exp 1 01 00 1",
                     bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done);
        end
        cyc();
        bus.funct = 6'h08;
        #1;
        repeat (2) cyc();
        checks++;
        if ({bus.pc_write, bus.pc_source, bus.instr_done, bus.reg_write} !== 5'b11110) begin
            errors++;
            $display("FAIL jr got pc=%b pcsrc=%b done=%b rw=%b exp 1 11 1 0",
                     bus.pc_write, bus.pc_source, bus.instr_done, bus.reg_write);
        end
        cyc();
        bus.funct = 6'h3F;
        #1;
        cyc();
        checks++;
        if ({bus.illegal_op, bus.instr_done, bus.reg_write} !== 3'b100) begin
            errors++;
            $display("FAIL illegal_funct_decode got ill=%b done=%b rw=%b exp 1 0 0",
                     bus.illegal_op, bus.instr_done, bus.reg_write);
        end
        cyc();
        checks++;
        if ({bus.mem_read, bus.illegal_op, bus.reg_write} !== 3'b100) begin
            errors++;
            $display("FAIL illegal_funct_refetch got rd=%b ill=%b rw=%b exp 1 0 0",
                     bus.mem_read, bus.illegal_op, bus.reg_write);
        end
        bus.funct = 6'h00;
    endtask

    task automatic test_sw_timeout();
        int wr_cycles;
        bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
        #1;
        repeat (2) cyc();
        checks++;
        if (bus.alu_op !== 3'b011) begin
            errors++;
            $display("FAIL sw_memaddr_aluop got %b exp 011", bus.alu_op);
        end
        bus.mem_ready = 1'b0;
        wr_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.mem_write && bus.i_or_d && !bus.mem_timeout) wr_cycles++;
        end
        checks++;
        if (wr_cycles !== 4) begin
            errors++;
            $display("FAIL sw_mem_write_cycles got %0d exp 4", wr_cycles);
        end
        cyc();
        checks++;
        if ({bus.mem_timeout, bus.mem_write, bus.instr_done} !== 3'b100) begin
            errors++;
            $display("FAIL sw_timeout_pulse got to=%b wr=%b done=%b exp 1 0 0",
                     bus.mem_timeout, bus.mem_write, bus.instr_done);
        end
        cyc();
        checks++;
        if ({bus.mem_read, bus.mem_write, bus.mem_timeout} !== 3'b100) begin
            errors++;
            $display("FAIL sw_timeout_refetch got rd=%b wr=%b to=%b exp 1 0 0",
                     bus.mem_read, bus.mem_write, bus.mem_timeout);
        end
    endtask

    task automatic test_reset_in_memwb();
        bus.opcode = 6'h23; bus.mem_ready = 1'b1;
        #1;
        repeat (4) cyc();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.reg_write, bus.instr_done, bus.mem_to_reg} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_memwb got rw=%b done=%b m2r=%b exp 0 0 00",
                     bus.reg_write, bus.instr_done, bus.mem_to_reg);
        end
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.mem_read, bus.ir_write, bus.i_or_d, bus.reg_write} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release_fetch got rd=%b ir=%b iord=%b rw=%b exp 1 1 0 0",
                     bus.mem_read, bus.ir_write, bus.i_or_d, bus.reg_write);
        end
    endtask

    task automatic test_jal();
        bus.opcode = 6'h03; bus.mem_ready = 1'b1;
        #1;
        cyc();
`ifdef MULTICYCLE_CONTROL_JAL_EN
        checks++;
        if (bus.illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL jal_decode_legal got ill=%b exp 0", bus.illegal_op);
        end
        cyc();
        checks++;
        if ({bus.pc_write, bus.pc_source, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done} !== 9'b110110101) begin
            errors++;
            $display("FAIL jal_exec got pc=%b pcsrc=%b rw=%b dst=%b m2r=%b done=%b exp 1 10 1 10 10 1",
                     bus.pc_write, bus.pc_source, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done);
        end
`else
        checks++;
        if ({bus.illegal_op, bus.instr_done} !== 2'b10) begin
            errors++;
            $display("FAIL jal_illegal got ill=%b done=%b exp 1 0", bus.illegal_op, bus.instr_done);
        end
`endif
        cyc();
        checks++;
        if ({bus.mem_read, bus.reg_write, bus.illegal_op} !== 3'b100) begin
            errors++;
            $display("FAIL jal_refetch got rd=%b rw=%b ill=%b exp 1 0 0",
                     bus.mem_read, bus.reg_write, bus.illegal_op);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_ori();
        test_lw();
        test_branch();
        test_rtype();
        test_sw_timeout();
        test_reset_in_memwb();
        test_jal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
